// File: rtl/act_pkg.sv
// Shared activation-unit constants and encodings.
package act_pkg;

    localparam int ACT_IN_WIDTH      = 8;
    localparam int ACT_OUT_WIDTH     = 16;
    // Full-range rescale: the quantized value lands in the top byte of the output word.
    localparam int ACT_DEQUANT_SHIFT = ACT_OUT_WIDTH - ACT_IN_WIDTH;

    typedef enum logic [1:0] {
        ACT_NONE    = 2'd0,
        ACT_RELU    = 2'd1,
        ACT_RELU6   = 2'd2,
        ACT_SIGMOID = 2'd3
    } act_type_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with synchronous reset and flush.
// The caller guarantees push only when !full || pop, and pop only when !empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      cnt;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    // Storage write; when full with a pop, wptr==rptr and the departing head is overwritten.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[wptr] <= wdata;
    end

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign level = cnt;
    // Head is forced to zero when empty so stale storage never shows on the output.
    assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/act_dequant_buffer.sv
// Dequantizing receive buffer: sign-extend and rescale quantized activations,
// buffer them, and present them on a valid/ready stream with a per-vector last flag.
module act_dequant_buffer
    import act_pkg::*;
#(
    parameter int IN_WIDTH   = ACT_IN_WIDTH,
    parameter int OUT_WIDTH  = ACT_OUT_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_WIDTH-1:0]           data_in,
    input  logic                          valid_in,
    input  logic [3:0]                    shift_amt,
    input  logic [LEN_WIDTH-1:0]          vec_len,
    input  logic                          flush,
    input  logic                          clr_ovf,
    output logic [OUT_WIDTH-1:0]          data_out,
    output logic                          valid_out,
    input  logic                          ready_out,
    output logic                          last_out,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow
);

    localparam logic [3:0] MAX_SHIFT = 4'(OUT_WIDTH - IN_WIDTH);

    logic                 full, empty, push, pop, drop;
    logic [3:0]           eff_shift;
    logic [OUT_WIDTH-1:0] ext, conv;
    logic [LEN_WIDTH-1:0] elem_cnt;

    // Rescale at push time; clamping the shift keeps the result inside OUT_WIDTH.
    always_comb begin
        eff_shift = (shift_amt > MAX_SHIFT) ? MAX_SHIFT : shift_amt;
        ext       = {{(OUT_WIDTH-IN_WIDTH){data_in[IN_WIDTH-1]}}, data_in};
        conv      = ext << eff_shift;
    end

    assign valid_out = !empty;
    assign pop       = valid_out && ready_out;
    assign push      = valid_in && (!full || pop);
    assign drop      = valid_in && full && !pop;

    sync_fifo_fwft #(.WIDTH(OUT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (conv),
        .rdata (data_out),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign last_out = (vec_len != '0) && (elem_cnt == vec_len - 1'b1) && valid_out;

    // Element counter advances per delivered word and restarts after the vector's last one.
    always_ff @(posedge clk) begin
        if (rst || flush)  elem_cnt <= '0;
        else if (pop)      elem_cnt <= last_out ? '0 : elem_cnt + 1'b1;
    end

    // Sticky drop flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)           overflow <= 1'b0;
        else if (drop)     overflow <= 1'b1;
        else if (clr_ovf)  overflow <= 1'b0;
    end

endmodule

// File: tb/tb_act_dequant_buffer.sv
// Randomized and directed bench for act_dequant_buffer against a queue-based reference model.
module tb_act_dequant_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  data_in = '0;
    logic        valid_in = 1'b0;
    logic [3:0]  shift_amt = 4'd8;
    logic [7:0]  vec_len = '0;
    logic        flush = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [15:0] data_out;
    logic        valid_out;
    logic        ready_out = 1'b0;
    logic        last_out;
    logic [2:0]  level;
    logic        overflow;

    int checks = 0;
    int failures = 0;

    // Reference state
    logic [15:0] mq[$];
    int          mcnt = 0;
    bit          movf = 1'b0;

    always #5 clk = ~clk;

    act_dequant_buffer dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .shift_amt(shift_amt), .vec_len(vec_len), .flush(flush), .clr_ovf(clr_ovf),
        .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
        .last_out(last_out), .level(level), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] conv(input logic [7:0] d, input logic [3:0] s);
        int e;
        int v;
        e = (s > 4'd8) ? 8 : int'(s);
        v = int'($signed(d));
        return 16'(v * (1 << e));
    endfunction

    function automatic bit model_last();
        return (vec_len != 0) && (mcnt == int'(vec_len) - 1) && (mq.size() > 0);
    endfunction

    // One clock: predict from the pre-edge state and inputs, then compare after the edge.
    task automatic cycle();
        bit          mvalid, mpop, mlast, mfull, drop, stall;
        logic [15:0] pv, prev_d;
        logic        prev_l;
        mvalid = mq.size() > 0;
        mpop   = mvalid && ready_out;
        mlast  = model_last();
        mfull  = mq.size() == 4;
        drop   = valid_in && mfull && !mpop;
        pv     = conv(data_in, shift_amt);
        stall  = valid_out && !ready_out && !rst && !flush;
        prev_d = data_out;
        prev_l = last_out;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mcnt = 0;
            movf = 1'b0;
        end else begin
            if (drop) movf = 1'b1;
            else if (clr_ovf) movf = 1'b0;
            if (flush) begin
                mq.delete();
                mcnt = 0;
            end else begin
                if (mpop) begin
                    void'(mq.pop_front());
                    mcnt = mlast ? 0 : (mcnt + 1) % 256;
                end
                if (valid_in && !drop) mq.push_back(pv);
            end
        end
        #1;
        chk("valid", valid_out, mq.size() > 0);
        chk("data", data_out, (mq.size() > 0) ? mq[0] : 16'h0);
        chk("last", last_out, model_last());
        chk("level", level, mq.size());
        chk("ovf", overflow, movf);
        if (stall) begin
            chk("stall_data", data_out, prev_d);
            chk("stall_last", last_out, prev_l);
        end
    endtask

    task automatic push_one(input logic [7:0] d);
        valid_in = 1'b1;
        data_in  = d;
        cycle();
        valid_in = 1'b0;
    endtask

    // Stream n elements with optional random stalls, checking last against element position.
    task automatic run_vec(input int n, input int vl, input bit rnd);
        int pushed = 0;
        int popped = 0;
        int guard = 0;
        while (popped < n && guard < 400) begin
            ready_out = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            valid_in  = (pushed < n) && (mq.size() < 4 || (ready_out && mq.size() > 0));
            data_in   = 8'($urandom);
            shift_amt = 4'($urandom);
            if (valid_out && ready_out) begin
                chk($sformatf("last_e%0d", popped + 1), last_out, (popped % vl) == vl - 1);
                popped++;
            end
            if (valid_in) pushed++;
            cycle();
            guard++;
        end
        if (guard >= 400) chk("run_vec_timeout", 0, 1);
        valid_in  = 1'b0;
        ready_out = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", overflow, 0);

        // Conversion, full-range shift
        ready_out = 1'b1;
        shift_amt = 4'd8;
        push_one(8'h7F); chk("conv_7f", data_out, 16'h7F00);
        push_one(8'h80); chk("conv_80", data_out, 16'h8000);
        push_one(8'h01); chk("conv_01", data_out, 16'h0100);
        cycle();

        // Partial and clamped shift
        shift_amt = 4'd4;  push_one(8'hFF); chk("conv_sh4", data_out, 16'hFFF0);
        shift_amt = 4'd15; push_one(8'h7F); chk("conv_clamp", data_out, 16'h7F00);
        cycle();

        // Overflow: fifth push is dropped
        ready_out = 1'b0;
        shift_amt = 4'd8;
        for (int i = 0; i < 5; i++) push_one(8'h10 + 8'(i));
        chk("ovf_level", level, 4);
        chk("ovf_set", overflow, 1);
        ready_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_out%0d", i), data_out, 16'h1000 + 16'(i * 256));
            cycle();
        end
        chk("ovf_drained", valid_out, 0);
        clr_ovf = 1'b1; cycle(); clr_ovf = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Full with simultaneous push and pop
        ready_out = 1'b0;
        for (int i = 0; i < 4; i++) push_one(8'h30 + 8'(i));
        ready_out = 1'b1;
        chk("fpp_head", data_out, 16'h3000);
        push_one(8'h20);
        chk("fpp_level", level, 4);
        chk("fpp_ovf", overflow, 0);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("fpp_out%0d", i), data_out, 16'h3000 + 16'(i * 256));
            cycle();
        end
        chk("fpp_last_word", data_out, 16'h2000);
        cycle();

        // Last flag, vec_len=3, seven elements with random stalls
        flush = 1'b1; cycle(); flush = 1'b0;
        vec_len = 8'd3;
        run_vec(7, 3, 1'b1);

        // Flush mid-stream; next vector counts from element 1
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) push_one(8'($urandom));
        flush = 1'b1; cycle(); flush = 1'b0;
        chk("flush_valid", valid_out, 0);
        chk("flush_level", level, 0);
        run_vec(3, 3, 1'b0);

        // vec_len=1: every element is last
        vec_len = 8'd1;
        run_vec(4, 1, 1'b1);

        // Reset mid-stream with two entries and overflow set
        ready_out = 1'b0;
        for (int i = 0; i < 5; i++) push_one(8'($urandom));
        ready_out = 1'b1; cycle(); cycle(); ready_out = 1'b0;
        chk("prerst_level", level, 2);
        chk("prerst_ovf", overflow, 1);
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("mrst_valid", valid_out, 0);
        chk("mrst_data", data_out, 0);
        chk("mrst_last", last_out, 0);
        chk("mrst_level", level, 0);
        chk("mrst_ovf", overflow, 0);

        // Random soak
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) vec_len = 8'($urandom_range(0, 5));
            valid_in  = 1'($urandom_range(0, 3) != 0);
            data_in   = 8'($urandom);
            shift_amt = 4'($urandom);
            ready_out = 1'($urandom_range(0, 2) != 0);
            clr_ovf   = ($urandom_range(0, 19) == 0);
            flush     = ($urandom_range(0, 49) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            cycle();
        end
        valid_in = 1'b0; clr_ovf = 1'b0; flush = 1'b0; rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/act_dequant_buffer.md
Name: act_dequant_buffer

Overview:
Receive side of the activation unit's quantized output stream. The block accepts one 8-bit quantized activation per cycle on a valid-only interface, which has no backpressure. It sign-extends and rescales each value back to 16-bit fixed point for the next layer's MAC array. Values are held in a small FIFO and presented on a valid/ready stream with a per-vector last flag.

Parameters:
IN_WIDTH, 8, width of quantized input activations
OUT_WIDTH, 16, width of dequantized output words
FIFO_DEPTH, 4, buffer entries (power of two, >=2)
LEN_WIDTH, 8, width of vector-length config and element counter

Ports:
clk  input  1  single clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
data_in  input  IN_WIDTH  signed quantized activation
valid_in  input  1  data_in valid; no ready, must be accepted or flagged
shift_amt  input  4  left-shift for rescale; values > OUT_WIDTH-IN_WIDTH clamp to OUT_WIDTH-IN_WIDTH
vec_len  input  LEN_WIDTH  elements per vector; 0 = last never asserted
flush  input  1  synchronous clear of FIFO and element counter
clr_ovf  input  1  clears sticky overflow flag
data_out  output  OUT_WIDTH  signed dequantized activation (FIFO head)
valid_out  output  1  head entry present
ready_out  input  1  downstream accepts when high with valid_out
last_out  output  1  head entry is last element of current vector
level  output  clog2(FIFO_DEPTH)+1  current occupancy
overflow  output  1  sticky: a valid_in was dropped

Behaviour:
- Reset (rst high at clk edge): FIFO empty, valid_out=0, data_out=0, last_out=0, level=0, overflow=0, element counter=0, read/write pointers=0.
- Conversion happens at push. Stored word = sign_extend(data_in, OUT_WIDTH) shifted left by the effective shift. Low bits are zero-filled. The shift can never overflow, so no saturation is needed.
- shift_amt is sampled per element at push. Changing shift_amt mid-stream affects only later pushes.
- push = valid_in && (!full || pop).
- pop = valid_out && ready_out.
- FIFO is first-word-fall-through with registered storage. A value pushed into an empty FIFO at edge N appears on data_out with valid_out=1 after edge N (latency 1).
- Full and pop in the same cycle: the push is accepted and level is unchanged.
- Full, no pop, valid_in=1: data_in is dropped, FIFO contents are unchanged, and overflow is set at the next edge.
- Empty with valid_in: push only. A pop cannot occur while empty.
- Stall: while valid_out && !ready_out, data_out and last_out hold stable.
- Element counter: increments on each pop. It wraps to 0 on the pop where last_out=1.
- last_out = (vec_len != 0) && (counter == vec_len-1) && valid_out, evaluated against the head entry.
- vec_len must be stable while a vector is in flight. A change takes effect against the current counter value.
- vec_len=1 asserts last_out on every element.
- overflow is sticky until clr_ovf. If clr_ovf and a new drop occur in the same cycle, overflow stays 1 because set wins.
- flush: at the edge, FIFO is emptied (pointers=0, level=0, valid_out=0) and counter=0. Any push in the same cycle is discarded. flush does not clear overflow.
- rst has priority over flush. Both are synchronous, so a reset mid-stream discards all buffered data with no partial output.
- Pointers wrap modulo FIFO_DEPTH. level ranges 0..FIFO_DEPTH. Full is level==FIFO_DEPTH.

Decomposition:
- Shared package act_pkg holds:
  - ACT_IN_WIDTH=8 and ACT_OUT_WIDTH=16 constants, also shared with the activation unit.
  - The ACT_DEQUANT_SHIFT default, equal to ACT_OUT_WIDTH-ACT_IN_WIDTH.
  - The activation-type encodings.
- One sub-module, sync_fifo_fwft:
  - Generic width/depth, single clock, synchronous active-high reset and flush.
  - Outputs level and full/empty.
  - act_dequant_buffer wraps it with the rescale, element counter, last flag and overflow logic.

Test Plan:
- Conversion, shift_amt=8, ready_out=1:
  - push 0x7F -> data_out=0x7F00 one cycle later.
  - push 0x80 -> 0x8000.
  - push 0x01 -> 0x0100.
- Clamp and partial shift:
  - shift_amt=4, push 0xFF -> 0xFFF0.
  - shift_amt=15, push 0x7F -> 0x7F00, clamped to 8.
- Overflow, ready_out=0:
  - Push 0x10,0x11,0x12,0x13,0x14 -> level=4, overflow=1.
  - Then ready_out=1 -> outputs 0x1000,0x1100,0x1200,0x1300 and 0x1400 is never seen.
  - clr_ovf -> overflow=0.
- Full with simultaneous push/pop:
  - FIFO full, ready_out=1, valid_in=1 with 0x20 -> level stays 4, overflow stays 0.
  - 0x2000 emerges after the four prior entries.
- Last flag, vec_len=3, seven elements streamed:
  - last_out=1 on elements 3 and 6 only.
  - Random ready_out stalls -> data_out and last_out stable during every stall.
- Flush and reset mid-stream:
  - Three entries buffered, flush=1 -> next cycle valid_out=0, level=0, and the following vector's last_out is counted from element 1.
  - rst=1 with two entries and overflow=1 -> all outputs 0 after the edge.
